// File: rtl/spwm_pkg.sv
// Shared SPWM definitions: carrier direction encoding and default carrier geometry.
package spwm_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int DEFAULT_WIDTH      = 6;
  localparam int DEFAULT_PEAK       = 32;
  localparam int DEFAULT_CHANNELS   = 3;
  localparam int DEFAULT_PRESCALE_W = 8;

endpackage

// File: rtl/spwm_carrier_gen_if.sv
// Control and carrier-output bundle between the SPWM carrier generator and its users.
interface spwm_carrier_gen_if #(
  parameter int WIDTH      = 6,
  parameter int CHANNELS   = 3,
  parameter int PRESCALE_W = 8
);

  logic                      en;
  logic [PRESCALE_W-1:0]     prescale;
  logic                      load;
  logic [CHANNELS*WIDTH-1:0] phase_init;
  logic [CHANNELS-1:0]       dir_init;
  logic [CHANNELS*WIDTH-1:0] carrier;
  logic [CHANNELS-1:0]       dir;
  logic [CHANNELS-1:0]       peak_pulse;
  logic [CHANNELS-1:0]       valley_pulse;
  logic                      step;

  modport master (
    output en, prescale, load, phase_init, dir_init,
    input  carrier, dir, peak_pulse, valley_pulse, step
  );

  modport slave (
    input  en, prescale, load, phase_init, dir_init,
    output carrier, dir, peak_pulse, valley_pulse, step
  );

endinterface

// File: rtl/spwm_carrier_channel.sv
// One symmetric triangular carrier: counts 0..PEAK..0 on each tick, with preload and extreme strobes.
module spwm_carrier_channel
  import spwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PEAK  = DEFAULT_PEAK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] phase_init,
  input  logic             dir_init,
  output logic [WIDTH-1:0] carrier,
  output logic             dir,
  output logic             peak_pulse,
  output logic             valley_pulse
);

  localparam logic [WIDTH-1:0] PEAK_V = WIDTH'(PEAK);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] load_value;
  dir_e             dir_q, dir_d;
  logic             peak_q, peak_d;
  logic             valley_q, valley_d;

  // Direction flips on the same edge the extreme is reached, so each extreme lasts exactly one step.
  always_comb begin
    load_value = (phase_init > PEAK_V) ? PEAK_V : phase_init;
    value_d    = value_q;
    dir_d      = dir_q;
    peak_d     = 1'b0;
    valley_d   = 1'b0;
    if (load) begin
      value_d = load_value;
      if (load_value == PEAK_V) begin
        dir_d = DIR_DOWN;
      end else if (load_value == ZERO_V) begin
        dir_d = DIR_UP;
      end else begin
        dir_d = dir_e'(dir_init);
      end
    end else if (tick) begin
      if (dir_q == DIR_UP) begin
        value_d = value_q + ONE_V;
        if (value_d == PEAK_V) begin
          dir_d  = DIR_DOWN;
          peak_d = 1'b1;
        end
      end else begin
        value_d = value_q - ONE_V;
        if (value_d == ZERO_V) begin
          dir_d    = DIR_UP;
          valley_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q  <= '0;
      dir_q    <= DIR_UP;
      peak_q   <= 1'b0;
      valley_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      dir_q    <= dir_d;
      peak_q   <= peak_d;
      valley_q <= valley_d;
    end
  end

  assign carrier      = value_q;
  assign dir          = dir_q;
  assign peak_pulse   = peak_q;
  assign valley_pulse = valley_q;

endmodule

// File: rtl/spwm_carrier_gen.sv
// Multi-channel SPWM carrier generator: one shared step prescaler driving CHANNELS triangular carriers in lockstep.
module spwm_carrier_gen
  import spwm_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PEAK       = DEFAULT_PEAK,
  parameter int CHANNELS   = DEFAULT_CHANNELS,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input logic               clk,
  input logic               rst_n,
  spwm_carrier_gen_if.slave bus
);

  generate
    if (PEAK < 2 || PEAK > (2 ** WIDTH) - 1) begin : g_bad_peak
      $error("spwm_carrier_gen: PEAK must be in 2 .. 2**WIDTH-1");
    end
  endgenerate

  localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0]     count_q, count_d;
  logic                      step_q, step_d;
  logic                      tick;
  logic [CHANNELS*WIDTH-1:0] carrier_w;
  logic [CHANNELS-1:0]       dir_w;
  logic [CHANNELS-1:0]       peak_w;
  logic [CHANNELS-1:0]       valley_w;

  // Using >= lets a prescale lowered below the running count take effect on the very next clock.
  always_comb begin
    tick    = bus.en && (count_q >= bus.prescale);
    step_d  = tick && !bus.load;
    count_d = count_q;
    if (bus.load || tick) begin
      count_d = '0;
    end else if (bus.en) begin
      count_d = count_q + PS_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
    spwm_carrier_channel #(
      .WIDTH (WIDTH),
      .PEAK  (PEAK)
    ) u_channel (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .load         (bus.load),
      .phase_init   (bus.phase_init[k*WIDTH +: WIDTH]),
      .dir_init     (bus.dir_init[k]),
      .carrier      (carrier_w[k*WIDTH +: WIDTH]),
      .dir          (dir_w[k]),
      .peak_pulse   (peak_w[k]),
      .valley_pulse (valley_w[k])
    );
  end

  assign bus.carrier      = carrier_w;
  assign bus.dir          = dir_w;
  assign bus.peak_pulse   = peak_w;
  assign bus.valley_pulse = valley_w;
  assign bus.step         = step_q;

endmodule

// File: tb/tb_spwm_carrier_gen.sv
// Self-checking bench for spwm_carrier_gen: per-clock scoreboard from a phase-position model plus scenario checks.
module tb_spwm_carrier_gen;
  import spwm_pkg::*;

  localparam int WIDTH      = 6;
  localparam int PEAK       = 32;
  localparam int CHANNELS   = 3;
  localparam int PRESCALE_W = 8;

  typedef struct packed {
    logic [CHANNELS*WIDTH-1:0] carrier;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       peak;
    logic [CHANNELS-1:0]       valley;
    logic                      step;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  spwm_carrier_gen_if #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .PRESCALE_W (PRESCALE_W)
  ) bus ();

  spwm_carrier_gen #(
    .WIDTH      (WIDTH),
    .PEAK       (PEAK),
    .CHANNELS   (CHANNELS),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_pos[CHANNELS];
  int   m_cnt   = 0;

  // Model tracks each carrier as a position 0..2*PEAK-1 around the triangle.
  function automatic exp_t snapshot(input logic [CHANNELS-1:0] pk,
                                    input logic [CHANNELS-1:0] vl,
                                    input logic stp);
    exp_t e;
    int   v;
    e = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      v = (m_pos[k] <= PEAK) ? m_pos[k] : 2 * PEAK - m_pos[k];
      e.carrier[k*WIDTH +: WIDTH] = WIDTH'(v);
      e.dir[k] = (m_pos[k] < PEAK) ? 1'b1 : 1'b0;
    end
    e.peak   = pk;
    e.valley = vl;
    e.step   = stp;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = {bus.carrier, bus.dir, bus.peak_pulse, bus.valley_pulse, bus.step};
      n_total++;
      if (a !== e)
        $display("[TB] FAIL scoreboard t=%0t got=%h expected=%h", $time, a, e);
      else
        n_pass++;
    end
  end

  task automatic cycle(input logic r_n, input logic e, input logic [PRESCALE_W-1:0] ps,
                       input logic ld);
    logic [CHANNELS-1:0] pk;
    logic [CHANNELS-1:0] vl;
    logic                stp;
    int                  v;
    rst_n        = r_n;
    bus.en       = e;
    bus.prescale = ps;
    bus.load     = ld;
    pk  = '0;
    vl  = '0;
    stp = 1'b0;
    if (!r_n) begin
      m_cnt = 0;
      for (int k = 0; k < CHANNELS; k++) m_pos[k] = 0;
    end else if (ld) begin
      m_cnt = 0;
      for (int k = 0; k < CHANNELS; k++) begin
        v = int'(bus.phase_init[k*WIDTH +: WIDTH]);
        if (v > PEAK) v = PEAK;
        if (v == PEAK || v == 0) m_pos[k] = v;
        else m_pos[k] = bus.dir_init[k] ? v : 2 * PEAK - v;
      end
    end else if (e) begin
      if (m_cnt >= int'(ps)) begin
        m_cnt = 0;
        stp   = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
          m_pos[k] = (m_pos[k] + 1) % (2 * PEAK);
          if (m_pos[k] == PEAK) pk[k] = 1'b1;
          if (m_pos[k] == 0)    vl[k] = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end
    sb.push_back(snapshot(pk, vl, stp));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.phase_init = '0;
    bus.dir_init   = '0;
    cycle(1'b0, 1'b0, 8'd0, 1'b0);
    cycle(1'b0, 1'b1, 8'd0, 1'b1);
    n_total++;
    if (bus.carrier !== '0 || bus.dir !== 3'b111 || bus.step !== 1'b0)
      $display("[TB] FAIL reset_state carrier=%h dir=%b step=%b required 0/111/0",
               bus.carrier, bus.dir, bus.step);
    else n_pass++;
  endtask

  task automatic test_free_run();
    int first_valley  = -1;
    int second_valley = -1;
    for (int i = 1; i <= 130; i++) begin
      cycle(1'b1, 1'b1, 8'd0, 1'b0);
      if (i == 1) begin
        n_total++;
        if (bus.carrier[5:0] !== 6'd1) $display("[TB] FAIL first_step got=%0d required=1", bus.carrier[5:0]);
        else n_pass++;
      end
      if (bus.peak_pulse[0] === 1'b1) begin
        n_total++;
        if (bus.carrier[5:0] !== 6'd32) $display("[TB] FAIL peak_value got=%0d required=32", bus.carrier[5:0]);
        else n_pass++;
      end
      if (bus.valley_pulse[0] === 1'b1) begin
        if (first_valley < 0) first_valley = i;
        else if (second_valley < 0) second_valley = i;
      end
    end
    n_total++;
    if (first_valley != 64 || second_valley != 128)
      $display("[TB] FAIL period valleys at %0d,%0d required 64,128", first_valley, second_valley);
    else n_pass++;
  endtask

  task automatic test_prescale();
    int steps = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 1'b1, 8'd3, 1'b0);
      if (bus.step === 1'b1) steps++;
    end
    n_total++;
    if (steps != 64) $display("[TB] FAIL prescale3_steps got=%0d required=64", steps);
    else n_pass++;
    n_total++;
    if (bus.carrier[5:0] !== 6'd2 || bus.dir[0] !== 1'b1)
      $display("[TB] FAIL prescale3_period got=%0d/%b required=2/1", bus.carrier[5:0], bus.dir[0]);
    else n_pass++;
  endtask

  task automatic test_load_phases();
    bus.phase_init = {6'd11, 6'd21, 6'd0};
    bus.dir_init   = 3'b101;
    cycle(1'b1, 1'b1, 8'd0, 1'b1);
    n_total++;
    if (bus.carrier !== {6'd11, 6'd21, 6'd0} || bus.dir !== 3'b101 || bus.step !== 1'b0)
      $display("[TB] FAIL load_phases got=%h/%b required=%h/101", bus.carrier, bus.dir,
               {6'd11, 6'd21, 6'd0});
    else n_pass++;
    for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b1, 8'd0, 1'b0);
    n_total++;
    if (bus.carrier !== {6'd13, 6'd19, 6'd24} || bus.dir !== 3'b010)
      $display("[TB] FAIL offsets_1000 got=%h/%b required=%h/010", bus.carrier, bus.dir,
               {6'd13, 6'd19, 6'd24});
    else n_pass++;
  endtask

  task automatic test_clamp();
    bus.phase_init = {6'd5, 6'd0, 6'd40};
    bus.dir_init   = 3'b101;
    cycle(1'b1, 1'b1, 8'd0, 1'b1);
    n_total++;
    if (bus.carrier !== {6'd5, 6'd0, 6'd32} || bus.dir !== 3'b110 ||
        bus.peak_pulse !== 3'b000 || bus.valley_pulse !== 3'b000)
      $display("[TB] FAIL clamp_load got=%h/%b pk=%b vl=%b required=%h/110 no strobes",
               bus.carrier, bus.dir, bus.peak_pulse, bus.valley_pulse, {6'd5, 6'd0, 6'd32});
    else n_pass++;
    cycle(1'b1, 1'b1, 8'd0, 1'b0);
    n_total++;
    if (bus.carrier !== {6'd6, 6'd1, 6'd31} || bus.dir !== 3'b110)
      $display("[TB] FAIL clamp_step got=%h/%b required=%h/110", bus.carrier, bus.dir,
               {6'd6, 6'd1, 6'd31});
    else n_pass++;
  endtask

  task automatic test_en_freeze();
    int bad = 0;
    bus.phase_init = {6'd9, 6'd4, 6'd17};
    bus.dir_init   = 3'b111;
    cycle(1'b1, 1'b1, 8'd2, 1'b1);
    cycle(1'b1, 1'b1, 8'd2, 1'b0);
    cycle(1'b1, 1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'd2, 1'b0);
      if (bus.carrier[5:0] !== 6'd17 || bus.dir[0] !== 1'b1 || bus.step !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("[TB] FAIL en_freeze got %0d moving clocks required 0", bad);
    else n_pass++;
    cycle(1'b1, 1'b1, 8'd2, 1'b0);
    n_total++;
    if (bus.carrier[5:0] !== 6'd18 || bus.step !== 1'b1)
      $display("[TB] FAIL en_resume got=%0d step=%b required=18/1", bus.carrier[5:0], bus.step);
    else n_pass++;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'd2, 1'b0);
    n_total++;
    if (bus.carrier[5:0] !== 6'd19) $display("[TB] FAIL en_cadence got=%0d required=19", bus.carrier[5:0]);
    else n_pass++;
  endtask

  task automatic test_prescale_shrink();
    cycle(1'b1, 1'b1, 8'd7, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'd7, 1'b0);
    n_total++;
    if (bus.carrier[5:0] !== 6'd17) $display("[TB] FAIL shrink_hold got=%0d required=17", bus.carrier[5:0]);
    else n_pass++;
    cycle(1'b1, 1'b1, 8'd1, 1'b0);
    n_total++;
    if (bus.step !== 1'b1 || bus.carrier[5:0] !== 6'd18)
      $display("[TB] FAIL shrink_tick step=%b carrier=%0d required=1/18", bus.step, bus.carrier[5:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.phase_init = {6'd30, 6'd3, 6'd25};
    bus.dir_init   = 3'b000;
    cycle(1'b1, 1'b1, 8'd0, 1'b1);
    cycle(1'b1, 1'b1, 8'd0, 1'b0);
    bus.phase_init = {6'd7, 6'd7, 6'd7};
    cycle(1'b0, 1'b1, 8'd0, 1'b1);
    n_total++;
    if (bus.carrier !== '0 || bus.dir !== 3'b111 || bus.peak_pulse !== 3'b000 ||
        bus.valley_pulse !== 3'b000 || bus.step !== 1'b0)
      $display("[TB] FAIL reset_mid got=%h/%b pk=%b vl=%b step=%b required 0/111 quiet",
               bus.carrier, bus.dir, bus.peak_pulse, bus.valley_pulse, bus.step);
    else n_pass++;
    cycle(1'b1, 1'b1, 8'd0, 1'b0);
    n_total++;
    if (bus.carrier !== {6'd1, 6'd1, 6'd1} || bus.valley_pulse !== 3'b000 || bus.step !== 1'b1)
      $display("[TB] FAIL reset_restart got=%h vl=%b step=%b required=%h/000/1",
               bus.carrier, bus.valley_pulse, bus.step, {6'd1, 6'd1, 6'd1});
    else n_pass++;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.prescale   = '0;
    bus.load       = 1'b0;
    bus.phase_init = '0;
    bus.dir_init   = '0;
    test_reset();
    test_free_run();
    test_prescale();
    test_load_phases();
    test_clamp();
    test_en_freeze();
    test_prescale_shrink();
    test_reset_mid();
    @(negedge clk);
    #1;
    n_total++;
    if (sb.size() != 0) $display("[TB] FAIL scoreboard_drain got=%0d pending required=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
